// File: rtl/warp_dispatch_arbiter.sv
// Warp dispatch arbiter: FIFO of warp descriptors feeding a pool of SIMD cores, one dispatch
// per cycle, round-robin or fixed-priority core choice.
module warp_dispatch_arbiter #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned TID_W       = 4,
  parameter int unsigned WID_W       = 4,
  parameter int unsigned ARB_MODE    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PC_W-1:0]                in_pc,
  input  logic [TID_W-1:0]               in_threads,
  input  logic [WID_W-1:0]               in_warp_id,
  input  logic [NUM_CORES-1:0]           core_done,
  output logic [NUM_CORES-1:0]           disp_valid,
  output logic [PC_W-1:0]                disp_pc,
  output logic [TID_W-1:0]               disp_threads,
  output logic [WID_W-1:0]               disp_warp_id,
  output logic [NUM_CORES-1:0]           core_busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           all_idle,
  output logic                           err_zero_thread,
  output logic                           err_spurious_done
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = $clog2(NUM_CORES);
  localparam logic [AW:0] CntOne = (AW+1)'(1);
  localparam logic [AW:0] CntFull = (AW+1)'(QUEUE_DEPTH);
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [CW-1:0] LastCore = CW'(NUM_CORES - 1);

  // Queue storage; emptiness is tracked by the pointers/count only.
  logic [PC_W-1:0]  pc_mem  [QUEUE_DEPTH];
  logic [TID_W-1:0] thr_mem [QUEUE_DEPTH];
  logic [WID_W-1:0] wid_mem [QUEUE_DEPTH];

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [NUM_CORES-1:0] core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0] disp_valid_q, disp_valid_d;
  logic [PC_W-1:0]      disp_pc_q, disp_pc_d;
  logic [TID_W-1:0]     disp_threads_q, disp_threads_d;
  logic [WID_W-1:0]     disp_warp_id_q, disp_warp_id_d;
  logic [CW-1:0]        last_grant_q, last_grant_d;
  logic                 err_zero_q, err_zero_d;
  logic                 err_spur_q, err_spur_d;

  logic                 accept;
  logic                 push;
  logic                 dispatch;
  logic                 grant_found;
  logic [CW-1:0]        grant_idx;
  logic [CW-1:0]        cand;
  logic [NUM_CORES-1:0] grant_onehot;

  assign in_ready = (count_q < CntFull);
  assign accept   = in_valid && in_ready && !rst;
  assign push     = accept && (in_threads != '0);

  // Core search: rotating start after last grant, or plain lowest index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (ARB_MODE == 0) begin
        cand = CW'((32'(last_grant_q) + 32'd1 + i) % NUM_CORES);
      end else begin
        cand = CW'(i);
      end
      if (!grant_found && !core_busy_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign dispatch = grant_found && (count_q != '0);

  always_comb begin
    grant_onehot = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      grant_onehot[k] = dispatch && (grant_idx == CW'(k));
    end
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    last_grant_d   = last_grant_q;
    disp_pc_d      = disp_pc_q;
    disp_threads_d = disp_threads_q;
    disp_warp_id_d = disp_warp_id_q;
    disp_valid_d   = grant_onehot;
    // Spurious done bits are dropped; genuine ones free the core for the next decision.
    core_busy_d    = (core_busy_q & ~core_done) | grant_onehot;
    err_zero_d     = accept && (in_threads == '0);
    err_spur_d     = |(core_done & ~core_busy_q);

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (dispatch) begin
      rd_ptr_d       = rd_ptr_q + PtrOne;
      last_grant_d   = grant_idx;
      disp_pc_d      = pc_mem[rd_ptr_q];
      disp_threads_d = thr_mem[rd_ptr_q];
      disp_warp_id_d = wid_mem[rd_ptr_q];
    end
    if (push && !dispatch) begin
      count_d = count_q + CntOne;
    end else if (dispatch && !push) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      core_busy_q    <= '0;
      disp_valid_q   <= '0;
      disp_pc_q      <= '0;
      disp_threads_q <= '0;
      disp_warp_id_q <= '0;
      last_grant_q   <= LastCore;
      err_zero_q     <= 1'b0;
      err_spur_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      core_busy_q    <= core_busy_d;
      disp_valid_q   <= disp_valid_d;
      disp_pc_q      <= disp_pc_d;
      disp_threads_q <= disp_threads_d;
      disp_warp_id_q <= disp_warp_id_d;
      last_grant_q   <= last_grant_d;
      err_zero_q     <= err_zero_d;
      err_spur_q     <= err_spur_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= in_pc;
      thr_mem[wr_ptr_q] <= in_threads;
      wid_mem[wr_ptr_q] <= in_warp_id;
    end
  end

  assign disp_valid        = disp_valid_q;
  assign disp_pc           = disp_pc_q;
  assign disp_threads      = disp_threads_q;
  assign disp_warp_id      = disp_warp_id_q;
  assign core_busy         = core_busy_q;
  assign queue_count       = count_q;
  assign all_idle          = (count_q == '0) && (core_busy_q == '0) && (disp_valid_q == '0);
  assign err_zero_thread   = err_zero_q;
  assign err_spurious_done = err_spur_q;

endmodule

// File: tb/tb_warp_dispatch_arbiter.sv
// Directed bench: round-robin instance (dut0) and fixed-priority instance (dut1) share stimulus.
module tb_warp_dispatch_arbiter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [3:0]  in_threads;
  logic [3:0]  in_warp_id;
  logic [3:0]  core_done;

  logic        in_ready0, all_idle0, err_zero0, err_spur0;
  logic [3:0]  disp_valid0, disp_threads0, disp_warp_id0, core_busy0;
  logic [31:0] disp_pc0;
  logic [2:0]  queue_count0;

  logic        in_ready1, all_idle1, err_zero1, err_spur1;
  logic [3:0]  disp_valid1, disp_threads1, disp_warp_id1, core_busy1;
  logic [31:0] disp_pc1;
  logic [2:0]  queue_count1;

  int checks = 0;
  int errors = 0;

  warp_dispatch_arbiter #(
    .NUM_CORES(4), .QUEUE_DEPTH(4), .PC_W(32), .TID_W(4), .WID_W(4), .ARB_MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_pc(in_pc),
    .in_threads(in_threads), .in_warp_id(in_warp_id), .core_done(core_done),
    .disp_valid(disp_valid0), .disp_pc(disp_pc0), .disp_threads(disp_threads0),
    .disp_warp_id(disp_warp_id0), .core_busy(core_busy0), .queue_count(queue_count0),
    .all_idle(all_idle0), .err_zero_thread(err_zero0), .err_spurious_done(err_spur0)
  );

  warp_dispatch_arbiter #(
    .NUM_CORES(4), .QUEUE_DEPTH(4), .PC_W(32), .TID_W(4), .WID_W(4), .ARB_MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_pc(in_pc),
    .in_threads(in_threads), .in_warp_id(in_warp_id), .core_done(core_done),
    .disp_valid(disp_valid1), .disp_pc(disp_pc1), .disp_threads(disp_threads1),
    .disp_warp_id(disp_warp_id1), .core_busy(core_busy1), .queue_count(queue_count1),
    .all_idle(all_idle1), .err_zero_thread(err_zero1), .err_spurious_done(err_spur1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] id, input logic [3:0] thr);
    in_valid   = v;
    in_warp_id = id;
    in_threads = thr;
    in_pc      = 32'h1000 + {28'd0, id};
  endtask

  logic [3:0] fill_ids [7];

  initial begin
    fill_ids = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd1};
    rst = 1'b1;
    core_done = 4'b0000;
    drive(1'b0, 4'd0, 4'd0);
    step();
    step();
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_all_idle", all_idle0, 1);
    chk("rst_count", queue_count0, 0);
    chk("rst_busy", core_busy0, 0);
    chk("rst_disp_valid", disp_valid0, 0);
    chk("rst_err_zero", err_zero0, 0);
    chk("rst_err_spur", err_spur0, 0);
    rst = 1'b0;

    // Zero-thread descriptor and spurious completions while idle
    drive(1'b1, 4'd3, 4'd0);
    step();
    drive(1'b0, 4'd0, 4'd0);
    chk("zt_err_pulse", err_zero0, 1);
    chk("zt_count", queue_count0, 0);
    chk("zt_all_idle", all_idle0, 1);
    step();
    chk("zt_err_drop", err_zero0, 0);
    core_done = 4'b0010;
    step();
    chk("sp_err_pulse", err_spur0, 1);
    chk("sp_busy", core_busy0, 0);
    core_done = 4'b1011;
    step();
    core_done = 4'b0000;
    chk("sp_multi_pulse", err_spur0, 1);
    step();
    chk("sp_err_drop", err_spur0, 0);

    // Five warps: four fill cores 0..3 in order, one stays queued
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'(i), 4'd8);
      step();
      if (i >= 2) begin
        chk("rr_disp_valid", disp_valid0, 64'(1) << (i - 2));
        chk("rr_disp_wid", disp_warp_id0, 64'(i - 1));
      end
    end
    drive(1'b0, 4'd0, 4'd0);
    step();
    chk("rr_pulse_drop", disp_valid0, 0);
    chk("rr_hold_wid", disp_warp_id0, 4);
    chk("rr_hold_pc", disp_pc0, 32'h1004);
    chk("rr_count", queue_count0, 1);
    chk("rr_busy", core_busy0, 4'b1111);
    chk("rr_in_ready", in_ready0, 1);
    chk("rr_not_idle", all_idle0, 0);

    // Core 2 completes; queued warp 5 goes there
    core_done = 4'b0100;
    step();
    core_done = 4'b0000;
    chk("done_busy", core_busy0, 4'b1011);
    chk("done_count", queue_count0, 1);
    chk("done_no_disp", disp_valid0, 0);
    step();
    chk("w5_disp_valid", disp_valid0, 4'b0100);
    chk("w5_wid", disp_warp_id0, 5);
    chk("w5_pc", disp_pc0, 32'h1005);
    chk("w5_threads", disp_threads0, 8);
    chk("w5_busy", core_busy0, 4'b1111);
    chk("w5_count", queue_count0, 0);
    step();
    chk("w5_drop", disp_valid0, 0);

    // Reset with three cores busy, two warps queued and a dispatch pending
    drive(1'b1, 4'd6, 4'd8);
    step();
    drive(1'b1, 4'd7, 4'd8);
    step();
    drive(1'b0, 4'd0, 4'd0);
    chk("pre_rst_count", queue_count0, 2);
    core_done = 4'b1000;
    step();
    core_done = 4'b0000;
    chk("pre_rst_busy", core_busy0, 4'b0111);
    rst = 1'b1;
    drive(1'b1, 4'd14, 4'd8);
    step();
    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0);
    chk("mid_rst_in_ready", in_ready0, 1);
    chk("mid_rst_all_idle", all_idle0, 1);
    chk("mid_rst_count", queue_count0, 0);
    chk("mid_rst_busy", core_busy0, 0);
    chk("mid_rst_disp_valid", disp_valid0, 0);
    chk("mid_rst_pc", disp_pc0, 0);
    chk("mid_rst_threads", disp_threads0, 0);
    chk("mid_rst_wid", disp_warp_id0, 0);
    chk("mid_rst_errs", {err_zero0, err_spur0}, 0);
    drive(1'b1, 4'd9, 4'd8);
    step();
    drive(1'b0, 4'd0, 4'd0);
    chk("post_rst_count", queue_count0, 1);
    step();
    chk("post_rst_core0", disp_valid0, 4'b0001);
    chk("post_rst_wid", disp_warp_id0, 9);
    chk("post_rst_empty", queue_count0, 0);

    // Fill all cores, then fill the queue to capacity
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, fill_ids[i], 4'd8);
      step();
    end
    chk("full_count", queue_count0, 4);
    chk("full_in_ready", in_ready0, 0);
    chk("full_busy", core_busy0, 4'b1111);
    drive(1'b1, 4'd2, 4'd8);
    core_done = 4'b0001;
    step();
    core_done = 4'b0000;
    chk("full_reject_count", queue_count0, 4);
    chk("full_reject_ready", in_ready0, 0);
    chk("full_done_busy", core_busy0, 4'b1110);
    step();
    chk("full_pop_disp", disp_valid0, 4'b0001);
    chk("full_pop_wid", disp_warp_id0, 13);
    chk("full_pop_count", queue_count0, 3);
    chk("full_pop_ready", in_ready0, 1);
    step();
    drive(1'b0, 4'd0, 4'd0);
    chk("refill_count", queue_count0, 4);
    chk("refill_ready", in_ready0, 0);

    // Fixed-priority instance
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("fp_rst_idle", all_idle1, 1);
    chk("fp_rst_ready", in_ready1, 1);
    chk("fp_rst_errs", {err_zero1, err_spur1}, 0);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 4'(i), 4'd8);
      step();
    end
    drive(1'b0, 4'd0, 4'd0);
    step();
    chk("fp_busy_full", core_busy1, 4'b1111);
    chk("fp_count2", queue_count1, 2);
    core_done = 4'b0101;
    step();
    core_done = 4'b0000;
    chk("fp_busy_freed", core_busy1, 4'b1010);
    step();
    chk("fp_first_core0", disp_valid1, 4'b0001);
    chk("fp_first_wid", disp_warp_id1, 5);
    chk("fp_first_pc", disp_pc1, 32'h1005);
    step();
    chk("fp_second_core2", disp_valid1, 4'b0100);
    chk("fp_second_wid", disp_warp_id1, 6);
    chk("fp_second_count", queue_count1, 0);
    drive(1'b1, 4'd7, 4'd8);
    step();
    drive(1'b1, 4'd8, 4'd8);
    step();
    drive(1'b0, 4'd0, 4'd0);
    chk("fp_requeue_count", queue_count1, 2);
    core_done = 4'b1010;
    step();
    core_done = 4'b0000;
    chk("fp_busy_odd_free", core_busy1, 4'b0101);
    step();
    chk("fp_low_core1", disp_valid1, 4'b0010);
    chk("fp_low_wid", disp_warp_id1, 7);
    chk("fp_low_threads", disp_threads1, 8);
    step();
    chk("fp_next_core3", disp_valid1, 4'b1000);
    chk("fp_next_wid", disp_warp_id1, 8);
    chk("fp_next_count", queue_count1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_dispatch_arbiter.md
WARP_DISPATCH_ARBITER -- requirements
Module: warp_dispatch_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4: number of SIMD cores served, 2..16.
REQ-002 Parameter QUEUE_DEPTH, default 8: warp queue entries, power of two, 2..64.
REQ-003 Parameter PC_W, default 32: starting-PC width.
REQ-004 Parameter TID_W, default 4: thread-count width.
REQ-005 Parameter WID_W, default 4: warp-id width.
REQ-006 Parameter ARB_MODE, default 0: 0 selects round-robin core choice, 1 selects fixed lowest-index-first.
REQ-007 Port clk  input  1  sole clock, all state on its rising edge.
REQ-008 Port rst  input  1  synchronous, active-high reset.
REQ-009 Port in_valid  input  1  an incoming warp descriptor is presented.
REQ-010 Port in_ready  output  1  the queue can accept a descriptor this cycle.
REQ-011 Port in_pc / in_threads / in_warp_id  input  PC_W / TID_W / WID_W  descriptor fields.
REQ-012 Port core_done  input  NUM_CORES  one-cycle pulse per core when its warp finishes.
REQ-013 Port disp_valid  output  NUM_CORES  one-hot or zero, one-cycle pulse naming the target core.
REQ-014 Port disp_pc / disp_threads / disp_warp_id  output  PC_W / TID_W / WID_W  fields of the dispatched warp, valid only with disp_valid.
REQ-015 Port core_busy  output  NUM_CORES  per-core occupancy bitmap.
REQ-016 Port queue_count  output  clog2(QUEUE_DEPTH)+1  current queue occupancy.
REQ-017 Port all_idle  output  1  queue empty and no core busy.
REQ-018 Port err_zero_thread  output  1  pulse: a descriptor with zero threads was accepted and discarded.
REQ-019 Port err_spurious_done  output  1  pulse: core_done was seen for a core that is not busy.

Function
REQ-020 A descriptor shall be accepted on a clock edge where in_valid and in_ready are both 1; in_ready shall be 1 exactly when queue_count < QUEUE_DEPTH, based on registered state.
REQ-021 An accepted descriptor with in_threads == 0 shall not be enqueued; err_zero_thread shall be 1 in the following cycle.
REQ-022 The queue shall be FIFO; read/write pointers shall wrap modulo QUEUE_DEPTH; it has no bypass path.
REQ-023 In each cycle the dispatch decision shall use registered state only: when the queue is non-empty and at least one core_busy bit is 0, exactly one core is selected.
REQ-024 ARB_MODE 0: the search starts at last_grant+1 modulo NUM_CORES and selects the first free core; last_grant shall update to the granted index.
REQ-025 ARB_MODE 1: the lowest-index free core shall be selected; last_grant shall still update.
REQ-026 On a decision, the head entry shall be popped, and on the next edge disp_valid[k], core_busy[k] and the disp_* fields shall be registered; disp_valid shall drop the cycle after.
REQ-027 Latency: a push in cycle N to an empty queue with a free core shall produce disp_valid in cycle N+2.
REQ-028 core_done[k] with core_busy[k]==1 shall clear core_busy[k] on the next edge; that core is eligible for a decision in that next cycle.
REQ-029 core_done[k] with core_busy[k]==0 shall be ignored, and err_spurious_done shall pulse in the next cycle; several in one cycle yield a single pulse.
REQ-030 Push and pop in the same cycle shall leave queue_count unchanged.
REQ-031 Multiple core_done bits in one cycle shall all be honoured.
REQ-032 At most one dispatch shall occur per cycle.
REQ-033 all_idle = (queue_count==0) && (core_busy==0) && (disp_valid==0).
REQ-034 disp_* fields shall hold their last values when disp_valid is 0.

Reset
REQ-035 While rst is 1 at an edge, the block shall perform the following on that edge: empty the queue, zero pointers and queue_count, clear core_busy, disp_valid, disp_* and both err outputs, and set last_grant to NUM_CORES-1.
REQ-036 After reset, in_ready=1 and all_idle=1.
REQ-037 Reset mid-operation shall discard queued and in-flight warps with no dispatch pulse issued.
REQ-038 A descriptor presented in a reset cycle shall not be accepted.

Verification (NUM_CORES=4, QUEUE_DEPTH=4, ARB_MODE=0 unless stated)
REQ-039 Push 5 warps (ids 1..5, threads=8) with core_done held 0 -> dispatched to cores 0,1,2,3 in order, warp 5 queued, queue_count=1.
REQ-040 Continue REQ-039 and pulse core_done[2] -> core_busy[2] clears next cycle, warp 5 then dispatches to core 2, queue_count=0.
REQ-041 ARB_MODE=1: cores 0 and 2 are free and two warps are queued -> first goes to core 0, second to core 2.
REQ-042 With no core free, push until full -> in_ready=0 at queue_count=4; in_valid during that cycle is not accepted; one core_done leads to in_ready=1 again after the pop.
REQ-043 Push with in_threads=0 -> err_zero_thread pulses once, queue_count stays 0; pulse core_done[1] while idle -> err_spurious_done pulses once.
REQ-044 Assert rst with 3 cores busy and 2 warps queued -> next cycle all outputs are 0 except in_ready=1 and all_idle=1, and the next push goes to core 0.
